// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the dmem_arbiter and the combinational data memory.
// The slave view is the arbiter; the master view is the requesters plus the memory itself.
interface dmem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    // Requester side
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              err;

    // Memory side
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              MemRead;
    logic              MemWrite;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  mem_read_data,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, err,
        output mem_address, mem_write_data, MemRead, MemWrite
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output mem_read_data,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, err,
        input  mem_address, mem_write_data, MemRead, MemWrite
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for a single-port combinational data memory (IDLE -> ACCESS -> DONE).
// Build option DMEM_ARB_FIXED_PRIO_EN: port 0 always wins contention and the round-robin pointer is removed.
module dmem_arbiter #(
    parameter int          DATA_W = 32,
    parameter int          ADDR_W = 32,
    parameter int unsigned DEPTH  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              oor_q, oor_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              any_req;
    logic              pick1;
    logic              sel_we;
    logic              sel_in_range;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign any_req = bus.req0 | bus.req1;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign pick1 = bus.req1 & ~bus.req0;
`else
    logic last1_q, last1_d;  // 1 when port 1 received the most recent grant
    assign pick1 = bus.req1 & (~bus.req0 | ~last1_q);
`endif

    assign sel_we       = pick1 ? bus.we1    : bus.we0;
    assign sel_addr     = pick1 ? bus.addr1  : bus.addr0;
    assign sel_wdata    = pick1 ? bus.wdata1 : bus.wdata0;
    assign sel_in_range = (sel_addr < ADDR_W'(DEPTH));

    always_comb begin
        state_d     = state_q;
        gnt_d       = 2'b00;
        rvalid_d    = 2'b00;
        rdata_d     = rdata_q;
        err_d       = 1'b0;
        oor_d       = oor_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
        last1_d     = last1_q;
`endif
        unique case (state_q)
            ACCESS: begin
                // Memory is combinational: its output is valid during the strobe cycle.
                rvalid_d = gnt_q;
                err_d    = oor_q;
                rdata_d  = mem_rd_q ? bus.mem_read_data : '0;
                state_d  = DONE;
            end
            IDLE, DONE: begin
                state_d = IDLE;
                if (any_req) begin
                    state_d     = ACCESS;
                    gnt_d       = pick1 ? 2'b10 : 2'b01;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    mem_rd_d    = ~sel_we & sel_in_range;
                    mem_wr_d    =  sel_we & sel_in_range;
                    oor_d       = ~sel_in_range;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                    last1_d     = pick1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= 2'b00;
            rvalid_q    <= 2'b00;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            oor_q       <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            oor_q       <= oor_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifndef DMEM_ARB_FIXED_PRIO_EN
    // Reset value 1 makes port 0 the preferred winner of the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last1_q <= 1'b1;
        end else begin
            last1_q <= last1_d;
        end
    end
`endif

    assign bus.gnt0           = gnt_q[0];
    assign bus.gnt1           = gnt_q[1];
    assign bus.rvalid0        = rvalid_q[0];
    assign bus.rvalid1        = rvalid_q[1];
    assign bus.rdata          = rdata_q;
    assign bus.err            = err_q;
    assign bus.mem_address    = mem_addr_q;
    assign bus.mem_write_data = mem_wdata_q;
    assign bus.MemRead        = mem_rd_q;
    assign bus.MemWrite       = mem_wr_q;

    a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_rd_q && mem_wr_q));

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        gnt_q != 2'b11);

    a_access_one_cycle: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ACCESS) |=> (state_q == DONE));
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural 8-word combinational memory.
module tb_dmem_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   passed = 0;
    int   wr_cnt = 0;
    int   rv0_cnt = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory word i starts as 0xA5A5_000i.
    logic [31:0] mem [8] = '{32'hA5A5_0000, 32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003,
                             32'hA5A5_0004, 32'hA5A5_0005, 32'hA5A5_0006, 32'hA5A5_0007};

    assign bus.mem_read_data = (bus.mem_address < 32'd8) ? mem[bus.mem_address[2:0]] : 32'h0;

    always @(posedge clk) begin
        if (bus.MemWrite && bus.mem_address < 32'd8) mem[bus.mem_address[2:0]] <= bus.mem_write_data;
    end

    always @(posedge clk) begin
        if (bus.MemWrite) wr_cnt++;
        if (bus.rvalid0)  rv0_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    endtask

    task automatic test_reset();
        logic [6:0] flags;
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        flags = {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.err, bus.MemRead, bus.MemWrite};
        checks++;
        if (flags !== 7'b0) $display("FAIL reset_flags: got %b expected 0000000", flags);
        else passed++;
        checks++;
        if (bus.rdata !== 32'h0) $display("FAIL reset_rdata: got %h expected 00000000", bus.rdata);
        else passed++;
        checks++;
        if ({bus.mem_address, bus.mem_write_data} !== 64'h0)
            $display("FAIL reset_mem_bus: got %h/%h expected 0/0", bus.mem_address, bus.mem_write_data);
        else passed++;
        rst_n = 1'b1;
        step();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'd2;
        #1;
        checks++;
        if (bus.gnt0 !== 1'b0) $display("FAIL read2_no_early_gnt: got %b expected 0", bus.gnt0);
        else passed++;
        step();
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.MemRead, bus.MemWrite} !== 4'b1010 || bus.mem_address !== 32'd2)
            $display("FAIL read2_access: got gnt0=%b gnt1=%b rd=%b wr=%b addr=%0d expected 1 0 1 0 2",
                     bus.gnt0, bus.gnt1, bus.MemRead, bus.MemWrite, bus.mem_address);
        else passed++;
        bus.req0 = 1'b0;
        step();
        checks++;
        if (bus.rvalid0 !== 1'b1 || bus.gnt0 !== 1'b0 || bus.err !== 1'b0 || bus.rdata !== 32'hA5A5_0002)
            $display("FAIL read2_done: got rvalid0=%b gnt0=%b err=%b rdata=%h expected 1 0 0 a5a50002",
                     bus.rvalid0, bus.gnt0, bus.err, bus.rdata);
        else passed++;
        step();
        checks++;
        if (bus.rvalid0 !== 1'b0 || bus.rdata !== 32'hA5A5_0002 || bus.MemRead !== 1'b0)
            $display("FAIL read2_hold: got rvalid0=%b rdata=%h rd=%b expected 0 a5a50002 0",
                     bus.rvalid0, bus.rdata, bus.MemRead);
        else passed++;
    endtask

    task automatic test_write_read();
        int wr_before;
        wr_before = wr_cnt;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'd5; bus.wdata1 = 32'hDEAD_BEEF;
        step();
        checks++;
        if ({bus.gnt1, bus.gnt0, bus.MemWrite, bus.MemRead} !== 4'b1010 ||
            bus.mem_address !== 32'd5 || bus.mem_write_data !== 32'hDEAD_BEEF)
            $display("FAIL wr5_access: got gnt1=%b gnt0=%b wr=%b rd=%b addr=%0d wdata=%h expected 1 0 1 0 5 deadbeef",
                     bus.gnt1, bus.gnt0, bus.MemWrite, bus.MemRead, bus.mem_address, bus.mem_write_data);
        else passed++;
        // Queue the read-back immediately so DONE arbitrates it straight into ACCESS.
        bus.we1 = 1'b0; bus.wdata1 = '0;
        step();
        checks++;
        if (bus.rvalid1 !== 1'b1 || bus.err !== 1'b0 || bus.MemWrite !== 1'b0 ||
            bus.rdata !== 32'h0 || bus.mem_address !== 32'h0)
            $display("FAIL wr5_done: got rvalid1=%b err=%b wr=%b rdata=%h addr=%h expected 1 0 0 0 0",
                     bus.rvalid1, bus.err, bus.MemWrite, bus.rdata, bus.mem_address);
        else passed++;
        step();
        checks++;
        if (bus.gnt1 !== 1'b1 || bus.MemRead !== 1'b1 || bus.mem_address !== 32'd5)
            $display("FAIL rd5_access: got gnt1=%b rd=%b addr=%0d expected 1 1 5",
                     bus.gnt1, bus.MemRead, bus.mem_address);
        else passed++;
        bus.req1 = 1'b0;
        step();
        checks++;
        if (bus.rvalid1 !== 1'b1 || bus.err !== 1'b0 || bus.rdata !== 32'hDEAD_BEEF)
            $display("FAIL rd5_done: got rvalid1=%b err=%b rdata=%h expected 1 0 deadbeef",
                     bus.rvalid1, bus.err, bus.rdata);
        else passed++;
        checks++;
        if (wr_cnt - wr_before !== 1)
            $display("FAIL wr5_strobe_cycles: got %0d expected 1", wr_cnt - wr_before);
        else passed++;
        step();
    endtask

    task automatic test_contention();
        logic [3:0]  seen, want;
        logic [31:0] want_data;
        int          port;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'd1;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'd6;
        for (int i = 0; i < 8; i++) begin
            step();
`ifdef DMEM_ARB_FIXED_PRIO_EN
            port = 0;
`else
            port = (i / 2) % 2;
`endif
            if (i % 2 == 0) want = (port == 0) ? 4'b0100 : 4'b1000;
            else            want = (port == 0) ? 4'b0001 : 4'b0010;
            seen = {bus.gnt1, bus.gnt0, bus.rvalid1, bus.rvalid0};
            checks++;
            if (seen !== want)
                $display("FAIL contention_cycle%0d: got {gnt1,gnt0,rv1,rv0}=%b expected %b", i, seen, want);
            else passed++;
            if (i % 2 == 1) begin
                want_data = (port == 0) ? 32'hA5A5_0001 : 32'hA5A5_0006;
                checks++;
                if (bus.rdata !== want_data)
                    $display("FAIL contention_rdata%0d: got %h expected %h", i, bus.rdata, want_data);
                else passed++;
            end
            if (i == 7) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
        end
        step();
    endtask

    task automatic test_out_of_range();
        int wr_before;
        wr_before = wr_cnt;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'd8; bus.wdata0 = 32'h0000_1234;
        step();
        checks++;
        if (bus.gnt0 !== 1'b1 || bus.MemWrite !== 1'b0 || bus.MemRead !== 1'b0)
            $display("FAIL oor_access: got gnt0=%b wr=%b rd=%b expected 1 0 0",
                     bus.gnt0, bus.MemWrite, bus.MemRead);
        else passed++;
        bus.req0 = 1'b0;
        step();
        checks++;
        if (bus.rvalid0 !== 1'b1 || bus.err !== 1'b1 || bus.rdata !== 32'h0)
            $display("FAIL oor_done: got rvalid0=%b err=%b rdata=%h expected 1 1 0",
                     bus.rvalid0, bus.err, bus.rdata);
        else passed++;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 32'd0; bus.wdata0 = '0;
        step();
        bus.req0 = 1'b0;
        step();
        checks++;
        if (bus.rvalid0 !== 1'b1 || bus.err !== 1'b0 || bus.rdata !== 32'hA5A5_0000)
            $display("FAIL oor_readback0: got rvalid0=%b err=%b rdata=%h expected 1 0 a5a50000",
                     bus.rvalid0, bus.err, bus.rdata);
        else passed++;
        checks++;
        if (wr_cnt - wr_before !== 0)
            $display("FAIL oor_no_write: got %0d write strobes expected 0", wr_cnt - wr_before);
        else passed++;
        step();
    endtask

    task automatic test_reset_mid();
        int rv_before;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'd3; bus.wdata0 = 32'hCAFE_F00D;
        step();
        checks++;
        if (bus.MemWrite !== 1'b1 || bus.gnt0 !== 1'b1)
            $display("FAIL mid_access: got wr=%b gnt0=%b expected 1 1", bus.MemWrite, bus.gnt0);
        else passed++;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.wdata0 = '0;
        rv_before = rv0_cnt;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.MemWrite !== 1'b0 || bus.gnt0 !== 1'b0 || bus.mem_address !== 32'h0)
            $display("FAIL mid_async_drop: got wr=%b gnt0=%b addr=%h expected 0 0 0",
                     bus.MemWrite, bus.gnt0, bus.mem_address);
        else passed++;
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (rv0_cnt - rv_before !== 0 || bus.rvalid0 !== 1'b0)
            $display("FAIL mid_no_rvalid: got %0d rvalid0 pulses expected 0", rv0_cnt - rv_before);
        else passed++;
        checks++;
        if (mem[3] !== 32'hA5A5_0003)
            $display("FAIL mid_mem3_unchanged: got %h expected a5a50003", mem[3]);
        else passed++;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 32'd3;
        step();
        checks++;
        if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0)
            $display("FAIL mid_req1_gnt: got gnt1=%b gnt0=%b expected 1 0", bus.gnt1, bus.gnt0);
        else passed++;
        bus.req1 = 1'b0;
        step();
        checks++;
        if (bus.rvalid1 !== 1'b1 || bus.rdata !== 32'hA5A5_0003)
            $display("FAIL mid_req1_done: got rvalid1=%b rdata=%h expected 1 a5a50003",
                     bus.rvalid1, bus.rdata);
        else passed++;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_write_read();
        test_contention();
        test_out_of_range();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
